pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 3: E-stage occupancy of MUL (opcode 00100); legal range 2..15.
REQ-002 SHALL have parameter MOD_CYCLES, default 8: E-stage occupancy of MOD (opcode 00000); legal range 2..15.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port opcode_e  input  5  opcode of the instruction in E.
REQ-006 SHALL have ports rs1_d, rs2_d  input  4  source registers in D.
REQ-007 SHALL have ports rs1_e, rs2_e  input  4  source registers in E.
REQ-008 SHALL have ports rd_e, rd_m, rd_w  input  4  destination registers in E/M/W.
REQ-009 SHALL have ports regw_e, regw_m, regw_w  input  1  register-write enables in E/M/W.
REQ-010 SHALL have port memread_e  input  1  E holds LB/LW (MemtoReg).
REQ-011 SHALL have port branch_taken_e  input  1  BEQ/BGT resolved taken in E.
REQ-012 SHALL have ports stall_f, stall_d, stall_e  output  1  hold PC / D / E registers.
REQ-013 SHALL have ports flush_d, flush_e, flush_m  output  1  insert bubble into D / E / M.
REQ-014 SHALL have ports fwd_a_e, fwd_b_e  output  2  operand select: 00 regfile, 01 from W, 10 from M.
REQ-015 SHALL have port mc_busy  output  1  high in MC_WAIT.

Function
REQ-016 SHALL implement FSM states RUN, MC_WAIT and a 4-bit down-counter cnt.
REQ-017 In RUN with opcode_e = MUL or MOD: SHALL load cnt = N-1 (N = MUL_CYCLES/MOD_CYCLES), assert stall_f, stall_d, stall_e, flush_m, move to MC_WAIT.
REQ-018 In MC_WAIT: SHALL decrement cnt each cycle; assert stall_f/d/e and flush_m while cnt > 1; at cnt = 1 deassert all, return to RUN; op therefore occupies E exactly N cycles.
REQ-019 Leaving MC_WAIT, the multicycle op SHALL have left E; no re-trigger on the next RUN cycle.
REQ-020 branch_taken_e in RUN: SHALL assert flush_d and flush_e same cycle; ignored in MC_WAIT.
REQ-021 Load-use in RUN (memread_e, regw_e, rd_e != 0, rd_e equals rs1_d or rs2_d): SHALL assert stall_f, stall_d, flush_e for one cycle.
REQ-022 Forwarding per operand: 10 if regw_m and rd_m != 0 and rd_m = rs_e; else 01 if same with W; else 00; M wins over W.
REQ-023 Register 0 SHALL never cause stall or forward.
REQ-024 All stall/flush/fwd outputs SHALL be combinational from inputs and state; zero latency.

Reset
REQ-025 rst_n low SHALL asynchronously force state RUN, cnt 0, and, while low, all outputs 0.
REQ-026 Reset mid-MC_WAIT SHALL abandon the op; first cycle after release is RUN.

Configuration
REQ-027 Macro PIPE_CTRL_FWD_EN defined: forwarding per REQ-022.
REQ-028 PIPE_CTRL_FWD_EN undefined: fwd_a_e/fwd_b_e tied 00; stall_f, stall_d, flush_e SHALL assert in RUN whenever rs1_d/rs2_d (non-zero) matches rd_e (regw_e) or rd_m (regw_m) or rd_w (regw_w).

Structure
REQ-029 Package proc_pkg SHALL hold opcode constants (OP_MOD, OP_MUL, OP_LB, OP_LW), REG_AW = 4, fwd-select enum, pipe_ctrl state enum.
REQ-030 Sub-module mc_timer (load/decrement/terminal-count) SHALL hold cnt; hazard and forwarding logic stay in pipe_ctrl.

Verification
REQ-031 MUL in E, MUL_CYCLES = 3 -> stall_f/d/e, flush_m high 2 cycles, low on 3rd; mc_busy high cycles 2-3.
REQ-032 LW rd_e = 5, rs2_d = 5 -> one-cycle stall_f, stall_d, flush_e; rd_e = 0 -> no stall.
REQ-033 rd_m = rd_w = 3, both regw, rs1_e = 3 -> fwd_a_e = 10; drop regw_m -> 01.
REQ-034 branch_taken_e in RUN -> flush_d, flush_e same cycle, no stalls.
REQ-035 MOD_CYCLES = 8, rst_n low at MC_WAIT cycle 4 -> outputs 0 immediately; after release, MOD still in E retriggers a full 8-cycle sequence.
REQ-036 FWD_EN undefined, regw_w, rd_w = 7, rs1_d = 7 -> stall asserted, fwd outputs 00.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor definitions: opcodes, register address width,
// forwarding-select encoding and the pipeline-controller state type.
package proc_pkg;

    localparam int unsigned REG_AW = 4;
    localparam int unsigned CNT_W  = 4;

    localparam logic [4:0] OP_MOD = 5'b00000;
    localparam logic [4:0] OP_MUL = 5'b00100;
    localparam logic [4:0] OP_LB  = 5'b01000;
    localparam logic [4:0] OP_LW  = 5'b01001;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        ST_RUN,
        ST_MC_WAIT
    } pc_state_t;

    // Operand bypass select for one E-stage source; M is younger so it wins.
    function automatic fwd_sel_t fwd_select(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rd_m,
        input logic              regw_m,
        input logic [REG_AW-1:0] rd_w,
        input logic              regw_w
    );
        fwd_sel_t sel;
        sel = FWD_RF;
        if (regw_m && (rd_m != '0) && (rd_m == rs)) begin
            sel = FWD_M;
        end else if (regw_w && (rd_w != '0) && (rd_w == rs)) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipe_ctrl_mc_timer.sv
// mc_timer: occupancy counter for multicycle E-stage operations.
// Load has priority over decrement; the counter never wraps below zero.
module mc_timer
    import proc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;

    // Count register: load start value, else step down toward zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Terminal count: last occupancy cycle (cnt 1, or 0 as a safe fallback).
    assign o_tc = (r_cnt <= CNT_W'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard, flush and forwarding control for a 5-stage pipeline.
// Build option: define PIPE_CTRL_FWD_EN to enable E-stage operand bypass;
// without it every in-flight RAW dependence on a D source stalls instead.
module pipe_ctrl
    import proc_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 3,
    parameter int unsigned MOD_CYCLES = 8
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        opcode_e,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              regw_e,
    input  logic              regw_m,
    input  logic              regw_w,
    input  logic              memread_e,
    input  logic              branch_taken_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_m,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic              mc_busy
);

`ifdef PIPE_CTRL_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    pc_state_t        r_state;
    pc_state_t        w_state_nxt;
    logic             w_is_mul;
    logic             w_is_mc;
    logic [CNT_W-1:0] w_load_val;
    logic             w_mc_load;
    logic             w_mc_dec;
    logic             w_mc_tc;
    logic             w_load_use;
    logic             w_raw_d;
    logic             w_hazard;
    fwd_sel_t         w_fwd_a;
    fwd_sel_t         w_fwd_b;
    logic             w_stall_f;
    logic             w_stall_d;
    logic             w_stall_e;
    logic             w_flush_d;
    logic             w_flush_e;
    logic             w_flush_m;

    assign w_is_mul   = (opcode_e == OP_MUL);
    assign w_is_mc    = w_is_mul || (opcode_e == OP_MOD);
    assign w_load_val = w_is_mul ? CNT_W'(MUL_CYCLES - 1) : CNT_W'(MOD_CYCLES - 1);
    assign w_mc_load  = (r_state == ST_RUN) && w_is_mc;
    assign w_mc_dec   = (r_state == ST_MC_WAIT);

    mc_timer u_mc_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_mc_load),
        .i_load_val (w_load_val),
        .i_dec      (w_mc_dec),
        .o_tc       (w_mc_tc)
    );

    // Data-hazard detection on the D-stage sources (register 0 never matches).
    always_comb begin
        w_load_use = memread_e && regw_e && (rd_e != '0) &&
                     ((rd_e == rs1_d) || (rd_e == rs2_d));
        w_raw_d    = 1'b0;
        if (rs1_d != '0) begin
            w_raw_d = w_raw_d || (regw_e && (rd_e == rs1_d)) ||
                      (regw_m && (rd_m == rs1_d)) || (regw_w && (rd_w == rs1_d));
        end
        if (rs2_d != '0) begin
            w_raw_d = w_raw_d || (regw_e && (rd_e == rs2_d)) ||
                      (regw_m && (rd_m == rs2_d)) || (regw_w && (rd_w == rs2_d));
        end
        w_hazard = FWD_EN ? w_load_use : (w_load_use || w_raw_d);
    end

    // E-stage operand bypass selects.
    always_comb begin
        w_fwd_a = FWD_RF;
        w_fwd_b = FWD_RF;
        if (FWD_EN) begin
            w_fwd_a = fwd_select(rs1_e, rd_m, regw_m, rd_w, regw_w);
            w_fwd_b = fwd_select(rs2_e, rd_m, regw_m, rd_w, regw_w);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and stall/flush decode.
    // In RUN a multicycle op outranks a branch, which outranks a data hazard:
    // a flushed D instruction needs no stall, and a stall must not kill the op.
    always_comb begin
        w_state_nxt = r_state;
        w_stall_f   = 1'b0;
        w_stall_d   = 1'b0;
        w_stall_e   = 1'b0;
        w_flush_d   = 1'b0;
        w_flush_e   = 1'b0;
        w_flush_m   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_is_mc) begin
                    w_stall_f   = 1'b1;
                    w_stall_d   = 1'b1;
                    w_stall_e   = 1'b1;
                    w_flush_m   = 1'b1;
                    w_state_nxt = ST_MC_WAIT;
                end else if (branch_taken_e) begin
                    w_flush_d = 1'b1;
                    w_flush_e = 1'b1;
                end else if (w_hazard) begin
                    w_stall_f = 1'b1;
                    w_stall_d = 1'b1;
                    w_flush_e = 1'b1;
                end
            end
            ST_MC_WAIT: begin
                if (!w_mc_tc) begin
                    w_stall_f = 1'b1;
                    w_stall_d = 1'b1;
                    w_stall_e = 1'b1;
                    w_flush_m = 1'b1;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Outputs are held low combinationally for the whole reset interval.
    assign stall_f = rst_n && w_stall_f;
    assign stall_d = rst_n && w_stall_d;
    assign stall_e = rst_n && w_stall_e;
    assign flush_d = rst_n && w_flush_d;
    assign flush_e = rst_n && w_flush_e;
    assign flush_m = rst_n && w_flush_m;
    assign fwd_a_e = rst_n ? w_fwd_a : 2'b00;
    assign fwd_b_e = rst_n ? w_fwd_b : 2'b00;
    assign mc_busy = rst_n && (r_state == ST_MC_WAIT);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: per-cycle expected control vectors are queued
// when inputs are driven and compared against the DUT at the falling edge.
// Expectations follow PIPE_CTRL_FWD_EN the same way the build does.
module tb_pipe_ctrl;
    import proc_pkg::*;

`ifdef PIPE_CTRL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // Control field groups: {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m}
    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_MC   = 6'b111001;
    localparam logic [5:0] C_LU   = 6'b110010;
    localparam logic [5:0] C_BR   = 6'b000110;
    localparam logic [4:0] OP_ADD = 5'b00001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  opcode_e;
    logic [3:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic        regw_e, regw_m, regw_w, memread_e, branch_taken_e;
    logic        stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mc_busy;
    logic [1:0]  fwd_a_e, fwd_b_e;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [10:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    pipe_ctrl #(
        .MUL_CYCLES (3),
        .MOD_CYCLES (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .opcode_e       (opcode_e),
        .rs1_d          (rs1_d),
        .rs2_d          (rs2_d),
        .rs1_e          (rs1_e),
        .rs2_e          (rs2_e),
        .rd_e           (rd_e),
        .rd_m           (rd_m),
        .rd_w           (rd_w),
        .regw_e         (regw_e),
        .regw_m         (regw_m),
        .regw_w         (regw_w),
        .memread_e      (memread_e),
        .branch_taken_e (branch_taken_e),
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .stall_e        (stall_e),
        .flush_d        (flush_d),
        .flush_e        (flush_e),
        .flush_m        (flush_m),
        .fwd_a_e        (fwd_a_e),
        .fwd_b_e        (fwd_b_e),
        .mc_busy        (mc_busy)
    );

    function automatic logic [10:0] ex(input logic [5:0] c, input logic [1:0] fa,
                                       input logic [1:0] fb, input logic busy);
        return {c, fa, fb, busy};
    endfunction

    task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%b exp=%b (sf sd se fd fe fm fa fb busy)", tag, obs, exp);
        end
    endtask

    task automatic idle();
        opcode_e       = OP_ADD;
        rs1_d          = '0;
        rs2_d          = '0;
        rs1_e          = '0;
        rs2_e          = '0;
        rd_e           = '0;
        rd_m           = '0;
        rd_w           = '0;
        regw_e         = 1'b0;
        regw_m         = 1'b0;
        regw_w         = 1'b0;
        memread_e      = 1'b0;
        branch_taken_e = 1'b0;
    endtask

    // Inputs are already driven (posedge+1); queue the expectation, compare
    // at the falling edge, then advance to just past the next rising edge.
    task automatic cyc(input string tag, input logic [10:0] e);
        logic [10:0] obs;
        logic [10:0] want;
        string       t;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        obs = {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, fwd_a_e, fwd_b_e, mc_busy};
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 11'h7ff, 11'h000);
        end else begin
            want = exp_q.pop_front();
            t    = tag_q.pop_front();
            chk(t, obs, want);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        // Reset with hazard-provoking inputs: everything must stay low.
        rst_n = 1'b0;
        idle();
        opcode_e       = OP_MUL;
        branch_taken_e = 1'b1;
        @(posedge clk);
        #1;
        cyc("reset_a", ex(C_NONE, 2'b00, 2'b00, 1'b0));
        cyc("reset_b", ex(C_NONE, 2'b00, 2'b00, 1'b0));

        rst_n = 1'b1;
        idle();
        cyc("idle", ex(C_NONE, 2'b00, 2'b00, 1'b0));

        // MUL: stalls for 2 cycles, low on the 3rd; branch ignored while waiting.
        opcode_e = OP_MUL;
        cyc("mul_c1", ex(C_MC, 2'b00, 2'b00, 1'b0));
        branch_taken_e = 1'b1;
        cyc("mul_c2", ex(C_MC, 2'b00, 2'b00, 1'b1));
        branch_taken_e = 1'b0;
        cyc("mul_c3", ex(C_NONE, 2'b00, 2'b00, 1'b1));
        idle();
        cyc("mul_done", ex(C_NONE, 2'b00, 2'b00, 1'b0));

        // Load-use.
        memread_e = 1'b1; regw_e = 1'b1; rd_e = 4'd5; rs1_d = 4'd2; rs2_d = 4'd5;
        cyc("lu_rs2", ex(C_LU, 2'b00, 2'b00, 1'b0));
        memread_e = 1'b0; regw_e = 1'b0; rd_e = 4'd0;
        cyc("lu_bubble", ex(C_NONE, 2'b00, 2'b00, 1'b0));
        memread_e = 1'b1; regw_e = 1'b1; rd_e = 4'd9; rs1_d = 4'd9; rs2_d = 4'd1;
        cyc("lu_rs1", ex(C_LU, 2'b00, 2'b00, 1'b0));
        rd_e = 4'd0; rs1_d = 4'd0; rs2_d = 4'd0;
        cyc("lu_r0", ex(C_NONE, 2'b00, 2'b00, 1'b0));
        idle();

        // Forwarding (D sources are r0, so no stall in either build).
        regw_m = 1'b1; rd_m = 4'd3; regw_w = 1'b1; rd_w = 4'd3; rs1_e = 4'd3; rs2_e = 4'd6;
        cyc("fwd_a_m", ex(C_NONE, FWD ? 2'b10 : 2'b00, 2'b00, 1'b0));
        regw_m = 1'b0;
        cyc("fwd_a_w", ex(C_NONE, FWD ? 2'b01 : 2'b00, 2'b00, 1'b0));
        regw_m = 1'b1; rd_m = 4'd4; rd_w = 4'd6; rs1_e = 4'd4; rs2_e = 4'd6;
        cyc("fwd_ab", ex(C_NONE, FWD ? 2'b10 : 2'b00, FWD ? 2'b01 : 2'b00, 1'b0));
        rd_m = 4'd0; rd_w = 4'd0; rs1_e = 4'd0; rs2_e = 4'd0;
        cyc("fwd_r0", ex(C_NONE, 2'b00, 2'b00, 1'b0));
        idle();

        // Taken branch in RUN.
        branch_taken_e = 1'b1;
        cyc("branch", ex(C_BR, 2'b00, 2'b00, 1'b0));
        idle();

        // RAW on D sources: stalls only without forwarding.
        regw_w = 1'b1; rd_w = 4'd7; rs1_d = 4'd7;
        cyc("raw_w", ex(FWD ? C_NONE : C_LU, 2'b00, 2'b00, 1'b0));
        regw_w = 1'b0; regw_m = 1'b1; rd_m = 4'd11; rs1_d = 4'd0; rs2_d = 4'd11;
        cyc("raw_m", ex(FWD ? C_NONE : C_LU, 2'b00, 2'b00, 1'b0));
        regw_m = 1'b0; regw_e = 1'b1; rd_e = 4'd12; rs1_d = 4'd12; rs2_d = 4'd0;
        cyc("raw_e", ex(FWD ? C_NONE : C_LU, 2'b00, 2'b00, 1'b0));
        regw_e = 1'b0; rd_w = 4'd7; rs1_d = 4'd7;
        cyc("raw_nowrite", ex(C_NONE, 2'b00, 2'b00, 1'b0));
        idle();

        // Modulo op interrupted by reset in its 4th wait cycle, then a full rerun.
        opcode_e = OP_MOD;
        cyc("mod_c1", ex(C_MC, 2'b00, 2'b00, 1'b0));
        for (int unsigned i = 0; i < 3; i++) begin
            cyc("mod_wait", ex(C_MC, 2'b00, 2'b00, 1'b1));
        end
        rst_n = 1'b0;
        cyc("mod_rst_async", ex(C_NONE, 2'b00, 2'b00, 1'b0));
        cyc("mod_rst_hold", ex(C_NONE, 2'b00, 2'b00, 1'b0));
        rst_n = 1'b1;
        cyc("mod_re_c1", ex(C_MC, 2'b00, 2'b00, 1'b0));
        for (int unsigned i = 0; i < 6; i++) begin
            cyc("mod_re_wait", ex(C_MC, 2'b00, 2'b00, 1'b1));
        end
        cyc("mod_re_last", ex(C_NONE, 2'b00, 2'b00, 1'b1));
        idle();
        cyc("mod_re_done", ex(C_NONE, 2'b00, 2'b00, 1'b0));

        if (exp_q.size() != 0) begin
            chk("scoreboard_left", 11'(exp_q.size()), 11'd0);
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
